sad_search_ctrl: RTL
====================

// Module: sad_search_ctrl
// PURPOSE
//  Scheduler for the SAD partial-sum datapath (accumulator with en_sad/rst_sad).
//  Runs one SAD per candidate block over N_CAND candidates and generates pixel addresses.
//  Tracks the minimum SAD and its candidate index, then reports them with a done/ack handshake.
//  Sits between the top-level init/ack control and the SAD datapath plus its pixel memories.
// PARAMETERS
//  N_CAND  4   number of candidate blocks searched per run (>=1)
//  N_PIX   16  pixels per block = accumulate cycles per candidate (>=2)
//  SAD_W   12  width of sad_in / best_sad
//  ADDR_W  6   address width; must satisfy 2**ADDR_W >= N_CAND*N_PIX
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       synchronous reset, active-high
//  init      in   1       start request, sampled only in IDLE
//  ack       in   1       result consumed, sampled only in DONE
//  sad_in    in   SAD_W   datapath accumulator value (valid 1 cycle after last en_sad)
//  en_sad    out  1       datapath accumulate enable
//  rst_sad   out  1       datapath accumulator clear
//  addr_a    out  ADDR_W  reference-block pixel address
//  addr_b    out  ADDR_W  candidate-block pixel address
//  busy      out  1       high in every state except IDLE
//  done      out  1       result valid, held until ack
//  best_idx  out  clog2(N_CAND) (min 1)  index of minimum-SAD candidate
//  best_sad  out  SAD_W   minimum SAD value
// BEHAVIOUR
//  - States: IDLE, CLR, ACC, CMP, DONE; outputs en_sad/rst_sad/busy/done decoded from state.
//  - rst (sync): state=IDLE, pix_cnt=0, cand=0, best_idx=0, best_sad=all ones,
//    en_sad=0, rst_sad=0, done=0, busy=0, addr_a=0, addr_b=0. Reset mid-run aborts it, no result.
//  - IDLE: init=1 -> CLR; otherwise stay. init ignored in all other states.
//  - CLR (1 cycle): rst_sad=1, pix_cnt<=0; if cand==0 also best_sad<=all ones and best_idx<=0. -> ACC.
//  - ACC (N_PIX cycles): en_sad=1, addr_a=pix_cnt, addr_b=cand*N_PIX+pix_cnt;
//    pix_cnt increments each cycle; at pix_cnt==N_PIX-1 -> CMP.
//  - CMP (1 cycle): if sad_in < best_sad (strict): best_sad<=sad_in, best_idx<=cand.
//    Ties keep the lower index. If cand==N_CAND-1 -> DONE, else cand<=cand+1 and -> CLR.
//  - DONE: done=1, best_* held stable; ack=1 -> IDLE, cand<=0. ack and init together: IDLE only.
//  - Latency: init sampled at edge E0 -> done high after edge E0+N_CAND*(N_PIX+2) (72 at defaults).
//  - Addresses hold their last value outside ACC. No overflow handling on sad_in; the datapath sizes SAD_W.
// CONFIGURATION
//  SAD_EARLY_TERM_EN defined: in ACC with cand>0, if sad_in >= best_sad then stop the candidate.
//    Go straight to CLR for the next candidate, or to DONE if it was the last.
//    best_* are not updated. cand==0 always runs all N_PIX cycles.
//  Not defined: every candidate runs the full N_PIX cycles, fixed latency as above.
// TESTING
//  1 rst=1 two cycles mid-idle -> en_sad=0 rst_sad=0 done=0 busy=0 best_idx=0 best_sad=12'hFFF.
//  2 datapath model gives SADs 40,25,60,25 -> done after E0+72, best_idx=1, best_sad=25.
//    Tie on candidate 3 is not taken.
//  3 check candidate 2 ACC -> addr_a 0..15, addr_b 32..47, en_sad high exactly 16 cycles.
//    rst_sad high 1 cycle before each ACC.
//  4 hold ack=0 for 10 cycles in DONE and pulse init -> done/best_* stable, no restart.
//    Then ack=1 -> done=0 and busy=0 next cycle.
//  5 rst=1 during candidate 2 ACC -> IDLE next edge, all outputs at reset values.
//    A new init restarts at cand 0 with addr_b=0.
//  6 SAD_EARLY_TERM_EN, cand0 SAD=10, later candidates reach 10 after 3 pixels -> each aborts early.
//    done before E0+72; best_idx=0, best_sad=10.

Source files
------------

// File: rtl/sad_search_ctrl_if.sv
// Handshake and datapath bus between the SAD search controller and its environment.
// master = controller side, slave = top-level control / SAD datapath side.
interface sad_search_ctrl_if #(
    parameter int N_CAND = 4,
    parameter int SAD_W  = 12,
    parameter int ADDR_W = 6
);
    localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

    logic              init;
    logic              ack;
    logic [SAD_W-1:0]  sad_in;
    logic              en_sad;
    logic              rst_sad;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  best_idx;
    logic [SAD_W-1:0]  best_sad;

    modport master (
        input  init, ack, sad_in,
        output en_sad, rst_sad, addr_a, addr_b, busy, done, best_idx, best_sad
    );

    modport slave (
        output init, ack, sad_in,
        input  en_sad, rst_sad, addr_a, addr_b, busy, done, best_idx, best_sad
    );
endinterface

// File: rtl/sad_search_ctrl.sv
// SAD search scheduler: one SAD per candidate block, tracks the minimum and reports it via done/ack.
// Optional SAD_EARLY_TERM_EN: abandon a candidate once its partial SAD reaches the current best.
module sad_search_ctrl #(
    parameter int N_CAND = 4,
    parameter int N_PIX  = 16,
    parameter int SAD_W  = 12,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    sad_search_ctrl_if.master bus
);
    localparam int IDX_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
    localparam int PIX_W = $clog2(N_PIX);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_ACC  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state;
    logic [PIX_W-1:0]  pix_cnt;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  best_idx;
    logic [SAD_W-1:0]  best_sad;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] addr_a_acc;
    logic [ADDR_W-1:0] addr_b_acc;
    logic              last_pix;
    logic              last_cand;
    logic              early_stop;

    always_comb begin
        last_pix   = (pix_cnt == PIX_W'(N_PIX - 1));
        last_cand  = (cand == IDX_W'(N_CAND - 1));
        addr_a_acc = ADDR_W'(pix_cnt);
        addr_b_acc = ADDR_W'(cand) * ADDR_W'(N_PIX) + ADDR_W'(pix_cnt);
`ifdef SAD_EARLY_TERM_EN
        // The accumulator only grows, so once it reaches best_sad this candidate cannot win.
        early_stop = (cand != '0) && (bus.sad_in >= best_sad);
`else
        early_stop = 1'b0;
`endif
    end

    // Addresses follow the counters during ACC and hold the last issued value elsewhere.
    assign bus.addr_a   = (state == S_ACC) ? addr_a_acc : addr_a_q;
    assign bus.addr_b   = (state == S_ACC) ? addr_b_acc : addr_b_q;
    assign bus.en_sad   = (state == S_ACC);
    assign bus.rst_sad  = (state == S_CLR);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.best_idx = best_idx;
    assign bus.best_sad = best_sad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pix_cnt  <= '0;
            cand     <= '0;
            best_idx <= '0;
            best_sad <= '1;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.init) state <= S_CLR;
                end
                S_CLR: begin
                    pix_cnt <= '0;
                    if (cand == '0) begin
                        best_sad <= '1;
                        best_idx <= '0;
                    end
                    state <= S_ACC;
                end
                S_ACC: begin
                    addr_a_q <= addr_a_acc;
                    addr_b_q <= addr_b_acc;
                    pix_cnt  <= pix_cnt + PIX_W'(1);
                    if (early_stop) begin
                        if (last_cand) begin
                            state <= S_DONE;
                        end else begin
                            cand  <= cand + IDX_W'(1);
                            state <= S_CLR;
                        end
                    end else if (last_pix) begin
                        state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (bus.sad_in < best_sad) begin
                        best_sad <= bus.sad_in;
                        best_idx <= cand;
                    end
                    if (last_cand) begin
                        state <= S_DONE;
                    end else begin
                        cand  <= cand + IDX_W'(1);
                        state <= S_CLR;
                    end
                end
                S_DONE: begin
                    if (bus.ack) begin
                        cand  <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
